// File: rtl/register_bank.sv
// Register bank with two combinational read ports and load/inc/dec/clear writes.
// Optional same-cycle write-to-read forwarding: define REGISTER_BANK_BYPASS_EN.
module register_bank #(
  parameter int          WIDTH     = 8,
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 2,
  parameter int unsigned RESET_VAL = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              zero_a,
  output logic              carry
);

  localparam int              LP_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] LP_RST  = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);
  localparam logic [ADDR_W:0]  LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  // Declaration initialisers give a deterministic power-up state before the first reset.
  logic [WIDTH-1:0] r_mem [DEPTH] = '{default: LP_RST};
  logic             r_carry = 1'b0;

  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic [WIDTH-1:0] w_old;
  logic [WIDTH-1:0] w_wnext;
  logic             w_cnext;
  logic             w_win;
  logic             w_wen;

  assign w_win = ({1'b0, waddr} < LP_DEPTH);
  assign w_wen = load & w_win;

  // Addresses at or beyond DEPTH never match an entry, so they read as zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    w_old  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (raddr_a == i[ADDR_W-1:0]) w_rd_a = r_mem[i[LP_IW-1:0]];
      if (raddr_b == i[ADDR_W-1:0]) w_rd_b = r_mem[i[LP_IW-1:0]];
      if (waddr   == i[ADDR_W-1:0]) w_old  = r_mem[i[LP_IW-1:0]];
    end
  end

  always_comb begin
    w_wnext = w_old;
    w_cnext = r_carry;
    case (op)
      2'b00: w_wnext = data;
      2'b01: begin
        w_wnext = w_old + LP_ONE;
        w_cnext = &w_old;
      end
      2'b10: begin
        w_wnext = w_old - LP_ONE;
        w_cnext = ~|w_old;
      end
      default: w_wnext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i[LP_IW-1:0]] <= LP_RST;
      r_carry <= 1'b0;
    end else if (w_wen) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (waddr == i[ADDR_W-1:0]) r_mem[i[LP_IW-1:0]] <= w_wnext;
      end
      r_carry <= w_cnext;
    end
  end

`ifdef REGISTER_BANK_BYPASS_EN
  logic w_byp;
  assign w_byp = load & rst_n & (op == 2'b00) & w_win;
  assign out_a = (w_byp && (raddr_a == waddr)) ? data : w_rd_a;
  assign out_b = (w_byp && (raddr_b == waddr)) ? data : w_rd_b;
`else
  assign out_a = w_rd_a;
  assign out_b = w_rd_b;
`endif

  assign zero_a = (out_a == '0);
  assign carry  = r_carry;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed scenarios then random traffic, checked against
// an arithmetic model of a 4-entry and a 3-entry bank driven by the same stimulus.
module tb_register_bank;

  logic       clk = 1'b0;
  logic       rst_n, load;
  logic [1:0] op, waddr, raddr_a, raddr_b;
  logic [7:0] data;
  logic [7:0] oa4, ob4, oa3, ob3;
  logic       za4, c4, za3, c3;

  int unsigned ncomp = 0;
  int unsigned nfail = 0;
  int unsigned m   [2][4];
  bit          mc  [2];
  int unsigned dep [2] = '{4, 3};

  always #5 clk = ~clk;

  register_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .RESET_VAL(10)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .load(load), .op(op), .waddr(waddr), .data(data),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(oa4), .out_b(ob4),
    .zero_a(za4), .carry(c4));

  register_bank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .RESET_VAL(10)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .load(load), .op(op), .waddr(waddr), .data(data),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .out_a(oa3), .out_b(ob3),
    .zero_a(za3), .carry(c3));

  function automatic int unsigned exp_rd(int k, int unsigned ra);
    if (ra >= dep[k]) return 0;
`ifdef REGISTER_BANK_BYPASS_EN
    if (load && rst_n && op == 2'b00 && waddr < dep[k] && ra == waddr) return data;
`endif
    return m[k][ra];
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 4; i++) m[k][i] = 10;
        mc[k] = 1'b0;
      end else if (load && waddr < dep[k]) begin
        case (op)
          2'd0: m[k][waddr] = data;
          2'd1: begin mc[k] = (m[k][waddr] == 255); m[k][waddr] = (m[k][waddr] + 1) % 256; end
          2'd2: begin mc[k] = (m[k][waddr] == 0); m[k][waddr] = (m[k][waddr] + 255) % 256; end
          default: m[k][waddr] = 0;
        endcase
      end
    end
  endtask

  task automatic cmp(string tag, int unsigned obs, int unsigned exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic r, logic ld, logic [1:0] o, logic [1:0] wa, logic [7:0] d,
                       logic [1:0] ra, logic [1:0] rb);
    rst_n = r; load = ld; op = o; waddr = wa; data = d; raddr_a = ra; raddr_b = rb;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(string tag);
    #1;
    cmp({tag, "/a4"}, oa4, exp_rd(0, raddr_a));
    cmp({tag, "/b4"}, ob4, exp_rd(0, raddr_b));
    cmp({tag, "/z4"}, za4, exp_rd(0, raddr_a) == 0);
    cmp({tag, "/c4"}, c4, mc[0]);
    cmp({tag, "/a3"}, oa3, exp_rd(1, raddr_a));
    cmp({tag, "/b3"}, ob3, exp_rd(1, raddr_b));
    cmp({tag, "/z3"}, za3, exp_rd(1, raddr_a) == 0);
    cmp({tag, "/c3"}, c3, mc[1]);
  endtask

  int unsigned coll_exp;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) m[k][i] = 10;
      mc[k] = 1'b0;
    end
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd1);
    check("powerup");
    cmp("powerup_const", oa4, 10);

    // reset, then read every address
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'(i), 2'(i));
      check("reset_rd");
    end
    cmp("reset_const_b", ob4, 10);
    cmp("reset_carry", c4, 0);

    // load and dual read
    drive(1'b1, 1'b1, 2'd0, 2'd2, 8'h5A, 2'd2, 2'd0);
    check("load_pre");
    tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd2, 2'd0);
    check("load_post");
    cmp("load_a_const", oa4, 8'h5A);
    cmp("load_b_const", ob4, 10);

    // increment wrap
    drive(1'b1, 1'b1, 2'd0, 2'd1, 8'hFF, 2'd1, 2'd2); tick();
    drive(1'b1, 1'b1, 2'd1, 2'd1, 8'h00, 2'd1, 2'd2); tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd1, 2'd2);
    check("inc_wrap");
    cmp("inc_wrap_val", oa4, 0);
    cmp("inc_wrap_carry", c4, 1);
    cmp("inc_wrap_zero", za4, 1);
    drive(1'b1, 1'b1, 2'd1, 2'd1, 8'h00, 2'd1, 2'd2); tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd1, 2'd2);
    check("inc_again");
    cmp("inc_again_val", oa4, 1);
    cmp("inc_again_carry", c4, 0);

    // decrement underflow, then load keeps carry
    drive(1'b1, 1'b1, 2'd3, 2'd3, 8'h00, 2'd3, 2'd1); tick();
    drive(1'b1, 1'b1, 2'd2, 2'd3, 8'h00, 2'd3, 2'd1); tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd3, 2'd1);
    check("dec_under");
    cmp("dec_under_val", oa4, 8'hFF);
    cmp("dec_under_carry", c4, 1);
    drive(1'b1, 1'b1, 2'd0, 2'd3, 8'h07, 2'd3, 2'd1); tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd3, 2'd1);
    check("load7");
    cmp("load7_val", oa4, 7);
    cmp("load7_carry", c4, 1);

    // write-read collision
`ifdef REGISTER_BANK_BYPASS_EN
    coll_exp = 8'h33;
`else
    coll_exp = 10;
`endif
    drive(1'b1, 1'b1, 2'd0, 2'd0, 8'h33, 2'd0, 2'd2);
    check("coll_pre");
    cmp("coll_pre_const", oa4, coll_exp);
    tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd0, 2'd2);
    check("coll_post");
    cmp("coll_post_const", oa4, 8'h33);

    // reset during a write
    drive(1'b0, 1'b1, 2'd0, 2'd1, 8'h77, 2'd1, 2'd1);
    check("rstw_pre");
    tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd1, 2'd0);
    check("rstw_post");
    cmp("rstw_val", oa4, 10);
    cmp("rstw_carry", c4, 0);

    // out-of-range write/read on the 3-entry bank
    drive(1'b1, 1'b1, 2'd0, 2'd3, 8'h55, 2'd3, 2'd2); tick();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'd3, 2'd2);
    check("oor");
    cmp("oor_a3", oa3, 0);
    cmp("oor_a4", oa4, 8'h55);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 2'(i), 2'd3);
      check("oor_hold");
    end

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(15) != 0), 1'($urandom), 2'($urandom), 2'($urandom),
            8'($urandom), 2'($urandom), 2'($urandom));
      if ($urandom_range(3) == 0) data = ($urandom_range(1) != 0) ? 8'hFF : 8'h00;
      check("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter WIDTH, default 8, is the data width of each register in bits (legal 1..32).
REQ-002 Parameter DEPTH, default 4, is the number of registers (legal 2..16).
REQ-003 Parameter ADDR_W, default 2, is the address width; it SHALL be at least ceil(log2(DEPTH)).
REQ-004 Parameter RESET_VAL, default 10, is the reset value of every register, truncated to WIDTH bits.
REQ-005 clk  in  1  is the single clock, and all state SHALL update on its rising edge.
REQ-006 rst_n  in  1  is the reset, which SHALL be synchronous and active-low.
REQ-007 load  in  1  is the write enable, and op is executed only when load=1.
REQ-008 op  in  2  is the write operation: 00 load data, 01 increment, 10 decrement, 11 clear.
REQ-009 waddr  in  ADDR_W  is the target register of the write.
REQ-010 data  in  WIDTH  is the write data, used only for op=00.
REQ-011 raddr_a, raddr_b  in  ADDR_W each  are the read port addresses.
REQ-012 out_a, out_b  out  WIDTH each  carry the read data of port A and port B.
REQ-013 zero_a  out  1  SHALL be 1 when out_a equals 0.
REQ-014 carry  out  1  is a registered wrap flag from the last executed increment or decrement.

Function
REQ-015 Reads are combinational: out_a = reg[raddr_a] and out_b = reg[raddr_b], and both ports SHALL read independently, including from the same address.
REQ-016 Write latency SHALL be 1 cycle: an op at edge N is visible on the read ports after edge N.
REQ-017 op=00 SHALL store data in reg[waddr].
REQ-018 op=01 SHALL store reg[waddr]+1 modulo 2^WIDTH, and SHALL set carry=1 if the old value was all-ones, otherwise carry=0.
REQ-019 op=10 SHALL store reg[waddr]-1 modulo 2^WIDTH, and SHALL set carry=1 if the old value was 0, otherwise carry=0.
REQ-020 op=11 SHALL store 0 in reg[waddr].
REQ-021 carry SHALL be unchanged by op=00, op=11, load=0, and out-of-range writes.
REQ-022 When load=0, all registers SHALL hold their values.
REQ-023 A write with waddr >= DEPTH SHALL be ignored.
REQ-024 A read with raddr >= DEPTH SHALL return 0.
REQ-025 A read of the address being written in the same cycle SHALL return the old value, unless REQ-031 applies.
REQ-026 Only reg[waddr] SHALL change on a write, and all other registers SHALL hold.

Reset
REQ-027 When rst_n=0 at a rising edge, every register SHALL be set to RESET_VAL and carry to 0, regardless of load and op.
REQ-028 Reset SHALL take priority over a simultaneous write, and the write SHALL be lost.
REQ-029 After a reset edge, out_a and out_b SHALL show RESET_VAL for in-range addresses, and zero_a SHALL reflect that value.
REQ-030 Before the first reset edge, register contents SHALL be RESET_VAL (power-up initial value) so that simulation is deterministic.

Configuration
REQ-031 With macro REGISTER_BANK_BYPASS_EN defined, when load=1, op=00, waddr is in range and a raddr equals waddr, that read port (and zero_a for port A) SHALL return data combinationally in the same cycle.
REQ-032 With REGISTER_BANK_BYPASS_EN defined, bypass SHALL NOT apply to ops 01, 10 or 11.
REQ-033 With REGISTER_BANK_BYPASS_EN defined, bypass SHALL NOT apply while rst_n=0.
REQ-034 Without REGISTER_BANK_BYPASS_EN, reads SHALL follow REQ-025 with no bypass logic present.

Verification
REQ-035 The bench SHALL cover reset: rst_n=0 for 1 edge, then read every address → out_a=out_b=10 and carry=0.
REQ-036 The bench SHALL cover load and dual read: load=1, op=00, waddr=2, data=0x5A, then raddr_a=2 and raddr_b=0 next cycle → out_a=0x5A, out_b=10.
REQ-037 The bench SHALL cover increment wrap: load 0xFF into reg1, then op=01 on reg1 → reg1=0x00, carry=1, zero_a=1 with raddr_a=1; a further op=01 → reg1=0x01, carry=0.
REQ-038 The bench SHALL cover decrement underflow: op=11 on reg3, then op=10 on reg3 → reg3=0xFF, carry=1; then op=00 with data=7 → reg3=7 and carry stays 1.
REQ-039 The bench SHALL cover write-read collision: load=1, op=00, waddr=0, data=0x33 with raddr_a=0 → out_a=10 during the cycle without the macro or 0x33 with REGISTER_BANK_BYPASS_EN, and 0x33 after the edge in both builds.
REQ-040 The bench SHALL cover reset mid-write: rst_n=0 with load=1, op=00, waddr=1, data=0x77 → reg1=10 and carry=0 after the edge; then, with DEPTH=3, a write to waddr=3 is ignored and raddr_a=3 → out_a=0.
